// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
//   Inter-stage pipeline register with valid/ready flow control and a 2-entry
//   skid buffer (main + skid). A control field is carried alongside the payload
//   and is forced to zero whenever its entry is empty or flushed; the payload is
//   never gated. in_ready_o comes straight from a flop, so a downstream stall
//   never forms a combinational path back to upstream.
//
// Ports
//   CLK          clock, all state updates on posedge
//   RST          asynchronous active-high reset
//   in_valid_i   upstream offers an entry
//   in_ready_o   stage can accept (= !skid_valid, registered)
//   in_ctrl_i    incoming control bits
//   in_data_i    incoming payload
//   flush_i      kill all held entries and the entry offered this cycle
//   out_valid_o  main entry valid
//   out_ready_i  downstream accepts the main entry
//   out_ctrl_o   main control bits, 0 when empty
//   out_data_o   main payload, holds its last value when empty
//   occ_o        number of held entries, 0..2
//
// Handshake: a transfer happens on a posedge where valid and ready are both 1
// on that interface. Upstream: acc = in_valid_i & in_ready_o & !flush_i.
// Downstream: pop = out_valid_o & out_ready_i. Valid must stay asserted with
// stable data until the transfer; ready may change freely.

module pipe_stage_skid #(
  parameter int unsigned              CTRL_W     = 4,
  parameter int unsigned              DATA_W     = 64,
  parameter logic [DATA_W-1:0]        RESET_DATA = '0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              flush_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        occ_o
);

  logic              main_valid;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic              skid_valid;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  logic acc;
  logic pop;

  assign in_ready_o  = ~skid_valid;
  assign out_valid_o = main_valid;
  assign out_ctrl_o  = main_ctrl & {CTRL_W{main_valid}};
  assign out_data_o  = main_data;
  assign occ_o       = {1'b0, main_valid} + {1'b0, skid_valid};

  assign acc = in_valid_i & in_ready_o & ~flush_i;
  assign pop = main_valid & out_ready_i;

  // The skid entry is only ever filled while main is valid and not popping,
  // so skid_valid implies main_valid and FIFO order is main first, then skid.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      main_valid <= 1'b0;
      main_ctrl  <= '0;
      main_data  <= RESET_DATA;
      skid_valid <= 1'b0;
      skid_ctrl  <= '0;
      skid_data  <= RESET_DATA;
    end else if (flush_i) begin
      // Payloads hold; only the valid and control bits are killed.
      main_valid <= 1'b0;
      main_ctrl  <= '0;
      skid_valid <= 1'b0;
      skid_ctrl  <= '0;
    end else if (skid_valid) begin
      // in_ready_o is low here, so nothing new can arrive this cycle.
      if (pop) begin
        main_valid <= 1'b1;
        main_ctrl  <= skid_ctrl;
        main_data  <= skid_data;
        skid_valid <= 1'b0;
        skid_ctrl  <= '0;
      end
    end else if (!main_valid || pop) begin
      if (acc) begin
        main_valid <= 1'b1;
        main_ctrl  <= in_ctrl_i;
        main_data  <= in_data_i;
      end else begin
        main_valid <= 1'b0;
        main_ctrl  <= '0;
      end
    end else if (acc) begin
      // Main is stalled: park the accepted entry in the skid slot.
      skid_valid <= 1'b1;
      skid_ctrl  <= in_ctrl_i;
      skid_data  <= in_data_i;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios followed by a long random run,
// all compared against a queue-based reference of the stage contents.

module tb_pipe_stage_skid;

  localparam int unsigned CTRL_W = 4;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned EW     = CTRL_W + DATA_W;
  localparam logic [DATA_W-1:0] RESET_DATA = 64'hDEAD_BEEF_0123_4567;

  logic              CLK;
  logic              RST;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [CTRL_W-1:0] in_ctrl_i;
  logic [DATA_W-1:0] in_data_i;
  logic              flush_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [CTRL_W-1:0] out_ctrl_o;
  logic [DATA_W-1:0] out_data_o;
  logic [1:0]        occ_o;

  pipe_stage_skid #(
    .CTRL_W     (CTRL_W),
    .DATA_W     (DATA_W),
    .RESET_DATA (RESET_DATA)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_ctrl_i   (in_ctrl_i),
    .in_data_i   (in_data_i),
    .flush_i     (flush_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_ctrl_o  (out_ctrl_o),
    .out_data_o  (out_data_o),
    .occ_o       (occ_o)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- scoreboard ----------------
  logic [EW-1:0]     exp_q[$];   // {ctrl, data}, front = main entry
  logic [DATA_W-1:0] held_data;  // payload shown when the stage is empty
  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic              ev;
    logic [CTRL_W-1:0] ec;
    logic [DATA_W-1:0] ed;
    logic [EW-1:0]     front;
    ev = (exp_q.size() != 0);
    ec = '0;
    ed = held_data;
    if (ev) begin
      front = exp_q[0];
      ec = front[EW-1:DATA_W];
      ed = front[DATA_W-1:0];
    end
    check_val({tag, ".valid"}, 64'(out_valid_o), 64'(ev));
    check_val({tag, ".ctrl"},  64'(out_ctrl_o),  64'(ec));
    check_val({tag, ".data"},  out_data_o,       ed);
    check_val({tag, ".occ"},   64'(occ_o),       64'(exp_q.size()));
    check_val({tag, ".ready"}, 64'(in_ready_o),  64'(exp_q.size() < 2));
  endtask

  // ---------------- driver ----------------
  // Drives one cycle of inputs (called #1 after a posedge), checks in_ready_o
  // mid-cycle, advances the reference at the edge, then checks all outputs.
  task automatic step(input string tag, input logic v, input logic [CTRL_W-1:0] c,
                      input logic [DATA_W-1:0] d, input logic f, input logic r);
    logic acc, pop;
    logic [EW-1:0] front;
    in_valid_i  = v;
    in_ctrl_i   = c;
    in_data_i   = d;
    flush_i     = f;
    out_ready_i = r;
    acc = v && (exp_q.size() < 2) && !f;
    pop = (exp_q.size() != 0) && r;
    #1;
    check_val({tag, ".ready_pre"}, 64'(in_ready_o), 64'(exp_q.size() < 2));
    @(posedge CLK);
    if (f) begin
      if (exp_q.size() != 0) begin
        front = exp_q[0];
        held_data = front[DATA_W-1:0];
      end
      exp_q.delete();
    end else begin
      if (pop) begin
        front = exp_q.pop_front();
        held_data = front[DATA_W-1:0];
      end
      if (acc) exp_q.push_back({c, d});
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic idle(input string tag, input logic r);
    step(tag, 1'b0, '0, 64'h0, 1'b0, r);
  endtask

  task automatic apply_reset();
    RST = 1'b1;
    #1;
    exp_q.delete();
    held_data = RESET_DATA;
    check_outputs("reset_async");
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DATA_W-1:0] a, b, c;
    RST = 1'b1;
    in_valid_i = 1'b0; in_ctrl_i = '0; in_data_i = '0;
    flush_i = 1'b0; out_ready_i = 1'b0;
    held_data = RESET_DATA;
    @(posedge CLK); #1;
    check_outputs("reset_init");
    @(posedge CLK); #1;
    RST = 1'b0;

    // T2: back-to-back stream 1..8, ctrl all ones
    for (int i = 1; i <= 8; i++) step("stream", 1'b1, 4'hF, 64'(i), 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) idle("stream_drain", 1'b1);

    // T3: stall, fill main+skid, C refused, then release in order
    a = 64'hAAAA_0001; b = 64'hBBBB_0002; c = 64'hCCCC_0003;
    step("stall_a", 1'b1, 4'h1, a, 1'b0, 1'b0);
    step("stall_b", 1'b1, 4'h2, b, 1'b0, 1'b0);
    step("stall_c", 1'b1, 4'h3, c, 1'b0, 1'b0);
    check_val("stall_full_occ", 64'(occ_o), 64'd2);
    step("release_c", 1'b1, 4'h3, c, 1'b0, 1'b1);   // skid->main, C refused
    step("release_c2", 1'b1, 4'h3, c, 1'b0, 1'b1);  // C accepted
    for (int i = 0; i < 3; i++) idle("release_drain", 1'b1);

    // T4: flush a full stage with an offered entry
    step("flush_fill0", 1'b1, 4'b1011, 64'h1111, 1'b0, 1'b0);
    step("flush_fill1", 1'b1, 4'b1011, 64'h2222, 1'b0, 1'b0);
    step("flush", 1'b1, 4'b1011, 64'h3333, 1'b1, 1'b0);
    check_val("flush_occ", 64'(occ_o), 64'd0);
    idle("flush_after", 1'b1);

    // Empty + valid + flush: nothing stored
    step("flush_empty", 1'b1, 4'hF, 64'h4444, 1'b1, 1'b1);
    idle("flush_empty_after", 1'b1);

    // T5: full + pop + valid: input refused, occ drops to 1
    step("simul_fill0", 1'b1, 4'h5, 64'h5555, 1'b0, 1'b0);
    step("simul_fill1", 1'b1, 4'h6, 64'h6666, 1'b0, 1'b0);
    step("simul", 1'b1, 4'h7, 64'h7777, 1'b0, 1'b1);
    check_val("simul_occ", 64'(occ_o), 64'd1);
    for (int i = 0; i < 3; i++) idle("simul_drain", 1'b1);

    // T1: reset mid-stream with occ=2
    step("rst_fill0", 1'b1, 4'h9, 64'h9999, 1'b0, 1'b0);
    step("rst_fill1", 1'b1, 4'hA, 64'hAAAA, 1'b0, 1'b0);
    apply_reset();
    idle("rst_after", 1'b1);

    // T6: random traffic
    for (int i = 0; i < 10000; i++) begin
      step("rand",
           1'($urandom_range(0, 3) != 0),
           4'($urandom_range(0, 15)),
           {32'($urandom), 32'($urandom)},
           1'($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 2) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
